wormhole_controller: RTL and testbench

//  Sequences the on-screen wormhole: spawn, lifetime, ship collision/teleport, cooldown.

---
 rtl/wormhole_controller.sv | 108 ++++++++++
 tb/tb_wormhole_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wormhole_controller.sv
// wormhole_controller: wormhole spawn/lifetime/teleport/cooldown sequencer; WORMHOLE_BLINK_EN blinks the final BLINK_FRAMES of the lifetime
module wormhole_controller #(
    parameter int SPAWN_DELAY_FRAMES = 30,
    parameter int LIFETIME_FRAMES = 300,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int X_MIN = 32,
    parameter int X_MAX = 575,
    parameter int Y_MIN = 32,
    parameter int Y_MAX = 415,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`ifdef WORMHOLE_BLINK_EN
    , parameter int BLINK_FRAMES = 60
`endif
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic enable,
    input  logic collisionShip,
    input  logic wormholeCheat,
    input  logic signed [10:0] topLeftX_Cheat,
    input  logic signed [10:0] topLeftY_Cheat,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic wormholeVisible,
    output logic teleportPulse,
    output logic signed [10:0] destX,
    output logic signed [10:0] destY,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, COOLDOWN} state_t;
    state_t cur, nxt;
    logic [15:0] lfsr, cnt, cnt_d;
    logic [11:0] rx, ry;
    logic [10:0] cx, cy;
    logic signed [10:0] tl_x, tl_y;
    logic last, hit, teleport, vis_d;
    assign rx = 12'(X_MIN) + {2'b00, lfsr[9:0]};
    assign ry = 12'(Y_MIN) + {3'b000, lfsr[15:7]};
    assign cx = 11'(rx > 12'(X_MAX) ? rx - 12'(X_MAX - X_MIN + 1) : rx);
    assign cy = 11'(ry > 12'(Y_MAX) ? ry - 12'(Y_MAX - Y_MIN + 1) : ry);
    assign last = cnt <= 16'd1;
    assign hit = collisionShip && wormholeVisible;
    assign teleport = enable && cur == ACTIVE && hit;
    assign state = cur;
    assign topLeftX = wormholeCheat ? topLeftX_Cheat : tl_x;
    assign topLeftY = wormholeCheat ? topLeftY_Cheat : tl_y;
`ifdef WORMHOLE_BLINK_EN
    assign vis_d = nxt == ACTIVE && (cnt_d > 16'(BLINK_FRAMES) || cnt_d[3]);
`else
    assign vis_d = nxt == ACTIVE;
`endif
    // next state and frame counter; collision outranks expiry, cheat freezes the lifetime
    always_comb begin
        nxt = cur;
        cnt_d = cnt;
        if (!enable) nxt = IDLE;
        else case (cur)
            IDLE: begin
                nxt = WAIT;
                cnt_d = 16'(SPAWN_DELAY_FRAMES);
            end
            WAIT: if (startOfFrame) begin
                nxt = last ? ACTIVE : WAIT;
                cnt_d = last ? 16'(LIFETIME_FRAMES) : cnt - 16'd1;
            end
            ACTIVE: if (hit) begin
                nxt = COOLDOWN;
                cnt_d = 16'(COOLDOWN_FRAMES);
            end else if (startOfFrame && !wormholeCheat) begin
                nxt = last ? WAIT : ACTIVE;
                cnt_d = last ? 16'(SPAWN_DELAY_FRAMES) : cnt - 16'd1;
            end
            default: if (startOfFrame) begin
                nxt = last ? WAIT : COOLDOWN;
                cnt_d = last ? 16'(SPAWN_DELAY_FRAMES) : cnt - 16'd1;
            end
        endcase
    end
    // state, LFSR and registered outputs; coordinates latch only on spawn and teleport
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cur <= IDLE;
            cnt <= '0;
            lfsr <= LFSR_SEED;
            tl_x <= 11'(X_MIN);
            tl_y <= 11'(Y_MIN);
            wormholeVisible <= 1'b0;
            teleportPulse <= 1'b0;
            destX <= '0;
            destY <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_d;
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            wormholeVisible <= vis_d;
            teleportPulse <= teleport;
            if (cur == WAIT && nxt == ACTIVE) begin
                tl_x <= $signed(cx);
                tl_y <= $signed(cy);
            end
            if (teleport) begin
                destX <= $signed(cx);
                destY <= $signed(cy);
            end
        end
    end
endmodule

// File: tb/tb_wormhole_controller.sv
// tb_wormhole_controller: randomized checks of wormhole_controller against a frame-level reference model
module tb_wormhole_controller;
    localparam int IDLE = 0, WAIT = 1, ACTIVE = 2, COOL = 3;
    logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, enable = 1'b0, col = 1'b0, cheat = 1'b0;
    logic signed [10:0] cx_in = '0, cy_in = '0;
    logic signed [10:0] tlx, tly, dx, dy;
    logic vis, pulse;
    logic [1:0] st;
    int n_cmp = 0, n_bad = 0;
    int m_phase, m_left, m_x, m_y, m_dx, m_dy;
    bit m_vis, m_pulse;
    logic [15:0] m_lfsr;

    wormhole_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(enable),
        .collisionShip(col), .wormholeCheat(cheat),
        .topLeftX_Cheat(cx_in), .topLeftY_Cheat(cy_in),
        .topLeftX(tlx), .topLeftY(tly), .wormholeVisible(vis),
        .teleportPulse(pulse), .destX(dx), .destY(dy), .state(st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fold(input int v, input int lo, input int hi);
        return v + lo > hi ? v + lo - (hi - lo + 1) : v + lo;
    endfunction

    task automatic model_reset();
        m_phase = IDLE; m_left = 0; m_x = 32; m_y = 32; m_dx = 0; m_dy = 0;
        m_vis = 0; m_pulse = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        int sx, sy;
        bit hit;
        if (!resetN) begin
            model_reset();
            return;
        end
        sx = fold(int'(m_lfsr) % 1024, 32, 575);
        sy = fold(int'(m_lfsr) / 128, 32, 415);
        hit = col && m_vis;
        m_pulse = 0;
        if (!enable) m_phase = IDLE;
        else if (m_phase == IDLE) begin
            m_phase = WAIT; m_left = 30;
        end else if (m_phase == WAIT) begin
            if (sof) begin
                if (m_left <= 1) begin
                    m_phase = ACTIVE; m_left = 300; m_x = sx; m_y = sy;
                end else m_left--;
            end
        end else if (m_phase == ACTIVE) begin
            if (hit) begin
                m_phase = COOL; m_left = 60; m_pulse = 1; m_dx = sx; m_dy = sy;
            end else if (sof && !cheat) begin
                if (m_left <= 1) begin
                    m_phase = WAIT; m_left = 30;
                end else m_left--;
            end
        end else if (sof) begin
            if (m_left <= 1) begin
                m_phase = WAIT; m_left = 30;
            end else m_left--;
        end
        m_vis = m_phase == ACTIVE;
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    endtask

    task automatic check_all();
        check("state", int'(st), m_phase);
        check("visible", int'(vis), int'(m_vis));
        check("pulse", int'(pulse), int'(m_pulse));
        check("topLeftX", int'(tlx), cheat ? int'(cx_in) : m_x);
        check("topLeftY", int'(tly), cheat ? int'(cy_in) : m_y);
        check("destX", int'(dx), m_dx);
        check("destY", int'(dy), m_dy);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic go_active();
        int i = 0;
        col = 0;
        while (m_phase != ACTIVE && i < 3000) begin
            sof = 1'($urandom_range(0, 1));
            cycle();
            i++;
        end
        sof = 0;
        check("reach_active", int'(st), ACTIVE);
        check("spawn_x_range", int'(tlx >= 32 && tlx <= 575), 1);
        check("spawn_y_range", int'(tly >= 32 && tly <= 415), 1);
    endtask

    task automatic hit_once();
        col = 1;
        cycle();
        col = 0;
        check("teleport_pulse", int'(pulse), 1);
        check("teleport_state", int'(st), COOL);
        check("dest_x_range", int'(dx >= 32 && dx <= 575), 1);
        check("dest_y_range", int'(dy >= 32 && dy <= 415), 1);
        cycle();
        check("pulse_one_clk", int'(pulse), 0);
    endtask

    initial begin
        int i;
        model_reset();
        @(negedge clk);
        check_all();
        check("reset_tlx", int'(tlx), 32);
        check("reset_state", int'(st), IDLE);
        resetN = 1;
        enable = 1;
        go_active();
        hit_once();
        i = 0;
        while (m_phase != WAIT && i < 1000) begin
            sof = 1'($urandom_range(0, 1));
            col = 1'($urandom_range(0, 1));
            cycle();
            i++;
        end
        col = 0;
        check("cooldown_to_wait", int'(st), WAIT);
        go_active();
        i = 0;
        while (m_phase == ACTIVE && i < 2000) begin
            sof = 1'($urandom_range(0, 1));
            cycle();
            i++;
        end
        check("expire_state", int'(st), WAIT);
        check("expire_visible", int'(vis), 0);
        go_active();
        i = 0;
        while (m_left > 1 && i < 1000) begin
            sof = 1;
            cycle();
            i++;
        end
        sof = 1;
        hit_once();
        sof = 0;
        go_active();
        cheat = 1; cx_in = -11'sd5; cy_in = 11'sd100;
        #1;
        check("cheat_x", int'(tlx), -5);
        check("cheat_y", int'(tly), 100);
        sof = 1;
        repeat (1000) cycle();
        sof = 0;
        check("cheat_still_active", int'(st), ACTIVE);
        cheat = 0;
        #1;
        check("cheat_restore_x", int'(tlx), m_x);
        hit_once();
        repeat (3) cycle();
        enable = 0;
        cycle();
        check("disable_idle", int'(st), IDLE);
        check("disable_pulse", int'(pulse), 0);
        enable = 1;
        go_active();
        repeat (5) cycle();
        resetN = 0;
        #1;
        model_reset();
        check_all();
        check("areset_x", int'(tlx), 32);
        check("areset_y", int'(tly), 32);
        repeat (2) cycle();
        resetN = 1;
        for (int k = 0; k < 5000; k++) begin
            enable = $urandom_range(0, 99) != 0;
            sof = $urandom_range(0, 2) == 0;
            col = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 199) == 0) cheat = ~cheat;
            if ($urandom_range(0, 49) == 0) begin
                cx_in = 11'($urandom_range(0, 2047));
                cy_in = 11'($urandom_range(0, 2047));
            end
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
